rf_write_arbiter: RTL

Shares the single register-file write port between NREQ writeback sources (ALU, load unit, PC-link, ...) in the multicycle processor. Grants one requester per cycle using a round-robin scheme. Registers the winner's address and data, and drives the enable and 4-bit select into the 4-to-16 write decoder, plus the write data to the register file. Honours a stall from the register-file side.

---
 rtl/cpu_pkg.sv | 15 +
 rtl/rr_arbiter.sv | 33 +++
 rtl/rf_write_arbiter.sv | 84 ++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared processor definitions: default datapath widths and the
// register-file write arbiter state encoding.
package cpu_pkg;

  localparam int NREQ_DEF = 4;
  localparam int AW_DEF   = 4;
  localparam int DW_DEF   = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    STALL = 2'd2
  } wr_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first set request at or after ptr,
// searching upward with wrap. The pointer register lives in the parent.
module rr_arbiter #(
  parameter  int NREQ = 4,
  localparam int PW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [PW-1:0]   ptr,
  input  logic            en,
  output logic [NREQ-1:0] gnt,
  output logic [PW-1:0]   win
);

  logic found;
  int   idx;

  always_comb begin
    // NOTE: every variable assigned here gets a default first, so no path leaves it holding state (no latch).
    gnt   = '0;
    win   = '0;
    found = 1'b0;
    idx   = 0;
    for (int k = 0; k < NREQ; k++) begin
      idx = (int'(ptr) + k) % NREQ;
      if (en && !found && req[idx]) begin
        found    = 1'b1;
        gnt[idx] = 1'b1;
        win      = PW'(idx);
      end
    end
  end

endmodule

// File: rtl/rf_write_arbiter.sv
// Round-robin arbiter for the single register-file write port. Registers the
// winning address/data toward the 4-to-16 write decoder and honours wp_stall.
module rf_write_arbiter
  import cpu_pkg::*;
#(
  parameter int NREQ = NREQ_DEF,
  parameter int AW   = AW_DEF,
  parameter int DW   = DW_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [NREQ-1:0]  req,
  input  logic [NREQ*AW-1:0] req_addr,
  input  logic [NREQ*DW-1:0] req_data,
  output logic [NREQ-1:0]  gnt,
  input  logic             wp_stall,
  output logic             dec_en,
  output logic [AW-1:0]    dec_addr,
  output logic [DW-1:0]    wr_data,
  output logic             busy
);

  localparam int PW = $clog2(NREQ);

  wr_state_e       state;
  logic [PW-1:0]   ptr;
  logic [PW-1:0]   win;
  logic [PW-1:0]   ptr_next;
  logic            arb_en;
  logic            grant;

  // A STALL that clears retires its write and may grant in the same cycle,
  // so only an active stall (outside IDLE) blocks arbitration. Gating with
  // rst_n drops the combinational grant the moment reset asserts.
  assign arb_en   = rst_n && ((state == IDLE) || !wp_stall);
  assign grant    = |gnt;
  assign ptr_next = (win == PW'(NREQ - 1)) ? '0 : win + PW'(1);

  rr_arbiter #(.NREQ(NREQ)) u_rr_arbiter (
    .req (req),
    .ptr (ptr),
    .en  (arb_en),
    .gnt (gnt),
    .win (win)
  );

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      ptr      <= '0;
      dec_en   <= 1'b0;
      dec_addr <= '0;
      wr_data  <= '0;
      busy     <= 1'b0;
    end else begin
      case (state)
        IDLE, WRITE, STALL: begin
          if (grant) begin
            state    <= WRITE;
            ptr      <= ptr_next;
            dec_en   <= 1'b1;
            busy     <= 1'b1;
            dec_addr <= req_addr[int'(win)*AW +: AW];
            wr_data  <= req_data[int'(win)*DW +: DW];
          end else if ((state != IDLE) && wp_stall) begin
            // Write port busy: hold the pending write exactly as presented.
            state <= STALL;
          end else begin
            state  <= IDLE;
            dec_en <= 1'b0;
            busy   <= 1'b0;
          end
        end
        default: begin
          state  <= IDLE;
          dec_en <= 1'b0;
          busy   <= 1'b0;
        end
      endcase
    end
  end

endmodule
